// File: rtl/seg7_scan_if.sv
// Bus bundle between a multiplexed 7-segment display scan and its decoder.
// The master drives segments and strobes; the slave returns decoded digits and frames.
interface seg7_scan_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   dig_en;
  logic                  digit_valid;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            digit_bcd;
  logic                  frame_valid;
  logic [4*N_DIGITS-1:0] bcd_out;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   err_mask;

  modport master (
    output seg, dig_en,
    input  digit_valid, digit_idx, digit_bcd, frame_valid, bcd_out, blank_mask, err_mask
  );

  modport slave (
    input  seg, dig_en,
    output digit_valid, digit_idx, digit_bcd, frame_valid, bcd_out, blank_mask, err_mask
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus: each digit is
// captured after a stable dwell and a full frame is published with blank/error masks.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SMP_W = 7 + N_DIGITS;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [N_DIGITS-1:0] DIG_ONE = N_DIGITS'(1);

  typedef enum logic [0:0] {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

  // Result packs {blank, err, code}; unknown patterns report code E.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'h08:   r = {2'b00, 4'd0};
      7'h6D:   r = {2'b00, 4'd1};
      7'h22:   r = {2'b00, 4'd2};
      7'h24:   r = {2'b00, 4'd3};
      7'h45:   r = {2'b00, 4'd4};
      7'h14:   r = {2'b00, 4'd5};
      7'h10:   r = {2'b00, 4'd6};
      7'h2D:   r = {2'b00, 4'd7};
      7'h00:   r = {2'b00, 4'd8};
      7'h04:   r = {2'b00, 4'd9};
      7'h7F:   r = {2'b10, 4'hF};
      default: r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  logic [SMP_W-1:0]      sample_q, sample_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  state_t                state_q, state_d;
  logic [4*N_DIGITS-1:0] slot_q, slot_d;
  logic [N_DIGITS-1:0]   blank_stage_q, blank_stage_d;
  logic [N_DIGITS-1:0]   err_stage_q, err_stage_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic                  digit_valid_q, digit_valid_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [3:0]            digit_bcd_q, digit_bcd_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [4*N_DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic [N_DIGITS-1:0]   blank_mask_q, blank_mask_d;
  logic [N_DIGITS-1:0]   err_mask_q, err_mask_d;

  logic                  changed_s;
  logic                  onehot_s;
  logic                  done_eff_s;
  logic                  reach_s;
  logic                  capture_s;
  logic [IDX_W-1:0]      idx_s;
  logic [5:0]            dec_s;

  always_comb begin
    sample_d  = {bus.seg, bus.dig_en};
    changed_s = (sample_d != sample_q);
    onehot_s  = (bus.dig_en != '0) && ((bus.dig_en & (bus.dig_en - DIG_ONE)) == '0);

    idx_s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bus.dig_en[i]) begin
        idx_s = IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end

    // A new sample restarts the dwell and re-arms the single capture per dwell.
    if (changed_s) begin
      cnt_d      = CNT_W'(1);
      done_eff_s = 1'b0;
    end else begin
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      done_eff_s = done_q;
    end
    reach_s   = (cnt_d == CNT_MAX) && !done_eff_s;
    done_d    = done_eff_s | reach_s;
    capture_s = reach_s && onehot_s;
    dec_s     = decode_seg(bus.seg);

    slot_d        = slot_q;
    blank_stage_d = blank_stage_q;
    err_stage_d   = err_stage_q;
    seen_d        = seen_q;
    digit_valid_d = capture_s;
    digit_idx_d   = digit_idx_q;
    digit_bcd_d   = digit_bcd_q;
    frame_valid_d = 1'b0;
    bcd_out_d     = bcd_out_q;
    blank_mask_d  = blank_mask_q;
    err_mask_d    = err_mask_q;

    case (state_q)
      PUBLISH: begin
        bcd_out_d     = slot_q;
        blank_mask_d  = blank_stage_q;
        err_mask_d    = err_stage_q;
        frame_valid_d = 1'b1;
        slot_d        = '0;
        blank_stage_d = '0;
        err_stage_d   = '0;
        seen_d        = '0;
      end
      COLLECT: begin
        frame_valid_d = 1'b0;
      end
      default: begin
        frame_valid_d = 1'b0;
      end
    endcase

    // Applied after the publish clear so a capture here lands in the next frame.
    if (capture_s) begin
      digit_idx_d                 = idx_s;
      digit_bcd_d                 = dec_s[3:0];
      slot_d[4*int'(idx_s) +: 4]  = dec_s[3:0];
      blank_stage_d[idx_s]        = dec_s[5];
      err_stage_d[idx_s]          = dec_s[4];
      seen_d[idx_s]               = 1'b1;
    end else begin
      digit_idx_d = digit_idx_q;
      digit_bcd_d = digit_bcd_q;
    end

    state_d = (seen_d == {N_DIGITS{1'b1}}) ? PUBLISH : COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q      <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      state_q       <= COLLECT;
      slot_q        <= '0;
      blank_stage_q <= '0;
      err_stage_q   <= '0;
      seen_q        <= '0;
      digit_valid_q <= 1'b0;
      digit_idx_q   <= '0;
      digit_bcd_q   <= 4'h0;
      frame_valid_q <= 1'b0;
      bcd_out_q     <= '0;
      blank_mask_q  <= '0;
      err_mask_q    <= '0;
    end else begin
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      state_q       <= state_d;
      slot_q        <= slot_d;
      blank_stage_q <= blank_stage_d;
      err_stage_q   <= err_stage_d;
      seen_q        <= seen_d;
      digit_valid_q <= digit_valid_d;
      digit_idx_q   <= digit_idx_d;
      digit_bcd_q   <= digit_bcd_d;
      frame_valid_q <= frame_valid_d;
      bcd_out_q     <= bcd_out_d;
      blank_mask_q  <= blank_mask_d;
      err_mask_q    <= err_mask_d;
    end
  end

  assign bus.digit_valid = digit_valid_q;
  assign bus.digit_idx   = digit_idx_q;
  assign bus.digit_bcd   = digit_bcd_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.bcd_out     = bcd_out_q;
  assign bus.blank_mask  = blank_mask_q;
  assign bus.err_mask    = err_mask_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random scans,
// compared against a dwell/frame reference model kept in this file.
module tb_seg7_scan_decoder;
  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_if #(.N_DIGITS(N)) ifc ();

  seg7_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Digit value k is shown by pattern pats[k]
  logic [6:0] pats [10] = '{7'h08, 7'h6D, 7'h22, 7'h24, 7'h45, 7'h14, 7'h10, 7'h2D, 7'h00, 7'h04};

  // Reference model: run length of identical samples, staging per digit, pending publish.
  logic [10:0]  m_prev;
  int           m_run;
  logic [3:0]   m_slot [N];
  logic [N-1:0] m_blank, m_err, m_seen;
  bit           m_pub;
  int           m_dv_cnt = 0;
  int           m_fv_cnt = 0;
  logic         e_dv, e_fv;
  logic [1:0]   e_idx;
  logic [3:0]   e_bcd;
  logic [15:0]  e_bcd_out;
  logic [N-1:0] e_blank_mask, e_err_mask;

  always @(posedge clk or posedge rst) begin : model_p
    int idx;
    int hit;
    logic [3:0] code;
    logic [10:0] smp;
    if (rst) begin
      m_prev = '0; m_run = 0; m_blank = '0; m_err = '0; m_seen = '0; m_pub = 0;
      for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
      e_dv = 1'b0; e_fv = 1'b0; e_idx = 2'd0; e_bcd = 4'h0;
      e_bcd_out = 16'h0; e_blank_mask = '0; e_err_mask = '0;
    end else begin
      smp = {ifc.seg, ifc.dig_en};
      if (smp != m_prev) m_run = 1;
      else m_run = m_run + 1;
      m_prev = smp;
      e_fv = m_pub;
      e_dv = 1'b0;
      if (m_pub) begin
        for (int i = 0; i < N; i++) e_bcd_out[4*i +: 4] = m_slot[i];
        e_blank_mask = m_blank;
        e_err_mask   = m_err;
        m_seen = '0;
        m_pub  = 0;
        m_fv_cnt++;
      end
      if (m_run == S && $countones(ifc.dig_en) == 1) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (ifc.dig_en[i]) idx = i;
        hit = -1;
        for (int k = 0; k < 10; k++) if (pats[k] == ifc.seg) hit = k;
        m_blank[idx] = 1'b0;
        m_err[idx]   = 1'b0;
        if (ifc.seg == 7'h7F) begin
          code = 4'hF; m_blank[idx] = 1'b1;
        end else if (hit >= 0) begin
          code = 4'(hit);
        end else begin
          code = 4'hE; m_err[idx] = 1'b1;
        end
        m_slot[idx] = code;
        m_seen[idx] = 1'b1;
        e_dv = 1'b1; e_idx = 2'(idx); e_bcd = code;
        m_dv_cnt++;
        if (m_seen == '1) m_pub = 1;
      end
    end
  end

  // Observation: counts cycles where DUT outputs differ from the model, plus pulses seen.
  int         mism = 0;
  int         dut_dv = 0;
  int         dut_fv = 0;
  logic [1:0] last_idx;
  logic [3:0] last_bcd;
  always @(negedge clk) begin
    if (ifc.digit_valid !== e_dv || ifc.frame_valid !== e_fv || ifc.bcd_out !== e_bcd_out ||
        ifc.blank_mask !== e_blank_mask || ifc.err_mask !== e_err_mask ||
        (e_dv && (ifc.digit_idx !== e_idx || ifc.digit_bcd !== e_bcd)))
      mism++;
    if (ifc.digit_valid === 1'b1) begin
      dut_dv++;
      last_idx = ifc.digit_idx;
      last_bcd = ifc.digit_bcd;
    end
    if (ifc.frame_valid === 1'b1) dut_fv++;
  end

  task automatic apply(input logic [6:0] s, input logic [3:0] e, input int n);
    for (int c = 0; c < n; c++) begin
      ifc.seg = s;
      ifc.dig_en = e;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (ifc.digit_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", ifc.digit_valid); else n_pass++;
    n_checks++; if (ifc.frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", ifc.frame_valid); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'h0) $display("FAIL reset_bcd_out: got %h want 0000", ifc.bcd_out); else n_pass++;
    n_checks++; if (ifc.blank_mask !== 4'h0) $display("FAIL reset_blank: got %b want 0000", ifc.blank_mask); else n_pass++;
    n_checks++; if (ifc.err_mask !== 4'h0) $display("FAIL reset_err: got %b want 0000", ifc.err_mask); else n_pass++;
    n_checks++; if (ifc.digit_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", ifc.digit_idx); else n_pass++;
    n_checks++; if (ifc.digit_bcd !== 4'h0) $display("FAIL reset_bcd: got %h want 0", ifc.digit_bcd); else n_pass++;
  endtask

  task automatic test_single_dwell();
    int dv0 = dut_dv, fv0 = dut_fv, mm0 = mism;
    apply(7'h08, 4'b0001, 6);
    n_checks++; if (dut_dv - dv0 !== 1) $display("FAIL dwell_pulses: got %0d want 1", dut_dv - dv0); else n_pass++;
    n_checks++; if (last_idx !== 2'd0) $display("FAIL dwell_idx: got %0d want 0", last_idx); else n_pass++;
    n_checks++; if (last_bcd !== 4'h0) $display("FAIL dwell_bcd: got %h want 0", last_bcd); else n_pass++;
    n_checks++; if (dut_fv - fv0 !== 0) $display("FAIL dwell_no_frame: got %0d want 0", dut_fv - fv0); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL dwell_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_scan();
    int dv0 = dut_dv, fv0 = dut_fv, mm0 = mism;
    apply(7'h24, 4'b0001, 4);
    apply(7'h45, 4'b0010, 4);
    apply(7'h2D, 4'b0100, 4);
    apply(7'h04, 4'b1000, 4);
    n_checks++; if (dut_fv - fv0 !== 0) $display("FAIL scan_early_frame: got %0d want 0", dut_fv - fv0); else n_pass++;
    apply(7'h04, 4'b0000, 1);
    n_checks++; if (dut_fv - fv0 !== 1) $display("FAIL scan_frame: got %0d want 1", dut_fv - fv0); else n_pass++;
    n_checks++; if (dut_dv - dv0 !== 4) $display("FAIL scan_pulses: got %0d want 4", dut_dv - dv0); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'h9743) $display("FAIL scan_bcd_out: got %h want 9743", ifc.bcd_out); else n_pass++;
    n_checks++; if (ifc.blank_mask !== 4'h0) $display("FAIL scan_blank: got %b want 0000", ifc.blank_mask); else n_pass++;
    n_checks++; if (ifc.err_mask !== 4'h0) $display("FAIL scan_err: got %b want 0000", ifc.err_mask); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL scan_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_short_dwell();
    int dv0 = dut_dv, fv0 = dut_fv, mm0 = mism;
    apply(7'h00, 4'b0001, 4);
    apply(7'h6D, 4'b0010, 4);
    apply(7'h22, 4'b0100, 3);
    apply(7'h14, 4'b1000, 4);
    apply(7'h14, 4'b0000, 2);
    n_checks++; if (dut_fv - fv0 !== 0) $display("FAIL short_no_frame: got %0d want 0", dut_fv - fv0); else n_pass++;
    n_checks++; if (dut_dv - dv0 !== 3) $display("FAIL short_pulses: got %0d want 3", dut_dv - dv0); else n_pass++;
    apply(7'h22, 4'b0100, 4);
    apply(7'h22, 4'b0000, 1);
    n_checks++; if (dut_fv - fv0 !== 1) $display("FAIL short_frame: got %0d want 1", dut_fv - fv0); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'h5218) $display("FAIL short_bcd_out: got %h want 5218", ifc.bcd_out); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL short_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_blank_err();
    int fv0 = dut_fv, mm0 = mism;
    apply(7'h10, 4'b0001, 4);
    apply(7'h7E, 4'b0010, 4);
    apply(7'h2D, 4'b0100, 4);
    apply(7'h7F, 4'b1000, 4);
    apply(7'h7F, 4'b0000, 1);
    n_checks++; if (dut_fv - fv0 !== 1) $display("FAIL be_frame: got %0d want 1", dut_fv - fv0); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'hF7E6) $display("FAIL be_bcd_out: got %h want F7E6", ifc.bcd_out); else n_pass++;
    n_checks++; if (ifc.blank_mask !== 4'b1000) $display("FAIL be_blank: got %b want 1000", ifc.blank_mask); else n_pass++;
    n_checks++; if (ifc.err_mask !== 4'b0010) $display("FAIL be_err: got %b want 0010", ifc.err_mask); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL be_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_bad_strobe();
    int dv0 = dut_dv, fv0, mm0 = mism;
    apply(7'h24, 4'b0000, 10);
    apply(7'h24, 4'b0110, 10);
    n_checks++; if (dut_dv - dv0 !== 0) $display("FAIL strobe_no_capture: got %0d want 0", dut_dv - dv0); else n_pass++;
    dv0 = dut_dv;
    fv0 = dut_fv;
    apply(7'h10, 4'b0001, 4);
    apply(7'h00, 4'b0001, 4);
    apply(7'h6D, 4'b0010, 4);
    apply(7'h22, 4'b0100, 4);
    apply(7'h24, 4'b1000, 4);
    apply(7'h24, 4'b0000, 1);
    n_checks++; if (dut_dv - dv0 !== 5) $display("FAIL recap_pulses: got %0d want 5", dut_dv - dv0); else n_pass++;
    n_checks++; if (dut_fv - fv0 !== 1) $display("FAIL recap_frame: got %0d want 1", dut_fv - fv0); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'h3218) $display("FAIL recap_bcd_out: got %h want 3218", ifc.bcd_out); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL recap_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int fv0, mm0;
    apply(7'h14, 4'b0001, 4);
    apply(7'h10, 4'b0010, 4);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ifc.bcd_out !== 16'h0) $display("FAIL midrst_bcd_out: got %h want 0000", ifc.bcd_out); else n_pass++;
    n_checks++; if (ifc.digit_valid !== 1'b0) $display("FAIL midrst_dv: got %b want 0", ifc.digit_valid); else n_pass++;
    n_checks++; if (ifc.digit_bcd !== 4'h0) $display("FAIL midrst_bcd: got %h want 0", ifc.digit_bcd); else n_pass++;
    @(negedge clk);
    #1 rst = 1'b0;
    fv0 = dut_fv;
    mm0 = mism;
    apply(7'h2D, 4'b0100, 4);
    apply(7'h00, 4'b1000, 4);
    apply(7'h00, 4'b0000, 2);
    n_checks++; if (dut_fv - fv0 !== 0) $display("FAIL midrst_stale_seen: got %0d frames want 0", dut_fv - fv0); else n_pass++;
    apply(7'h14, 4'b0001, 4);
    apply(7'h10, 4'b0010, 4);
    apply(7'h10, 4'b0000, 1);
    n_checks++; if (dut_fv - fv0 !== 1) $display("FAIL midrst_frame: got %0d want 1", dut_fv - fv0); else n_pass++;
    n_checks++; if (ifc.bcd_out !== 16'h8765) $display("FAIL midrst_bcd_out2: got %h want 8765", ifc.bcd_out); else n_pass++;
    n_checks++; if (mism - mm0 !== 0) $display("FAIL midrst_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
  endtask

  task automatic test_random();
    int mm0 = mism, dv0 = dut_dv, fv0 = dut_fv;
    int mdv0 = m_dv_cnt, mfv0 = m_fv_cnt;
    logic [6:0] s;
    logic [3:0] e;
    int d, r;
    for (int t = 0; t < 150; t++) begin
      d = $urandom_range(0, 3);
      r = $urandom_range(0, 11);
      if (r < 10) s = pats[r];
      else if (r == 10) s = 7'h7F;
      else s = 7'($urandom);
      e = 4'b0001 << d;
      if ($urandom_range(0, 7) == 0) e = 4'($urandom);
      apply(s, e, $urandom_range(1, 6));
    end
    n_checks++; if (mism - mm0 !== 0) $display("FAIL rand_model: got %0d differing cycles want 0", mism - mm0); else n_pass++;
    n_checks++; if (dut_dv - dv0 !== m_dv_cnt - mdv0) $display("FAIL rand_digits: got %0d want %0d", dut_dv - dv0, m_dv_cnt - mdv0); else n_pass++;
    n_checks++; if (dut_fv - fv0 !== m_fv_cnt - mfv0) $display("FAIL rand_frames: got %0d want %0d", dut_fv - fv0, m_fv_cnt - mfv0); else n_pass++;
  endtask

  initial begin
    ifc.seg = 7'h00;
    ifc.dig_en = 4'b0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_single_dwell();
    test_scan();
    test_short_dwell();
    test_blank_err();
    test_bad_strobe();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
